// File: rtl/alu_pkg.sv
// Shared opcodes, instruction field positions and FSM state type for the
// ALU execute-stage sequencer.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam int OPC_LSB     = 13;
  localparam int IMM_SEL_BIT = 12;
  localparam int RD_LSB      = 9;
  localparam int RS_LSB      = 6;
  localparam int IMM_LSB     = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_WB
  } state_t;

  // ADD..CMP go through the ALU; LDI and the illegal opcode do not.
  function automatic logic uses_alu(input logic [2:0] op);
    return (op <= OP_CMP);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake from fetch plus the operand/result bus to the ALU.
interface alu_sequencer_if #(parameter int DW = 8);

  logic [15:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] alu_in1;
  logic [DW-1:0] alu_in2;
  logic [2:0]    alu_select;
  logic          alu_active;
  logic [DW-1:0] alu_out;
  logic          alu_c;
  logic          alu_z;

  modport master (
    input  instr, instr_valid, alu_out, alu_c, alu_z,
    output instr_ready, alu_in1, alu_in2, alu_select, alu_active
  );

  modport slave (
    output instr, instr_valid, alu_out, alu_c, alu_z,
    input  instr_ready, alu_in1, alu_in2, alu_select, alu_active
  );

endinterface

// File: rtl/alu_sequencer_reg_file8.sv
// Register file: one synchronous write port, three combinational read ports
// (rd, rs, debug). A read in the write cycle returns the old value.
module reg_file8 #(
  parameter  int DW   = 8,
  parameter  int NREG = 8,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  input  logic [AW-1:0] rs_addr_i,
  output logic [DW-1:0] rs_data_o,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [DW-1:0] dbg_data_o
);

  logic [DW-1:0] regs_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (we_i && (waddr_i == AW'(k))) regs_q[k] <= wdata_i;
      end
    end
  end

  assign rd_data_o  = regs_q[rd_addr_i];
  assign rs_data_o  = regs_q[rs_addr_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Execute-stage controller: accepts an instruction, drives the external ALU
// with a toggle strobe, then writes back the result or latches the flags.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_sequencer_if.master        bus,
  output logic                   c_flag,
  output logic                   z_flag,
  output logic                   done,
  output logic                   err,
  input  logic [2:0]             dbg_addr,
  output logic [DW-1:0]          dbg_data
);

  state_t        state_q, state_d;
  logic [15:0]   instr_q, instr_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [2:0]    sel_q, sel_d;
  logic          act_q, act_d;
  logic          c_q, c_d, z_q, z_d;
  logic          done_q, done_d, err_q, err_d;

  logic          we;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rd_val, rs_val;

  logic [2:0]    opc;
  logic [2:0]    rd_idx, rs_idx;
  logic [DW-1:0] imm;

  assign opc    = instr_q[OPC_LSB +: 3];
  assign rd_idx = instr_q[RD_LSB +: 3];
  assign rs_idx = instr_q[RS_LSB +: 3];
  assign imm    = instr_q[IMM_LSB +: DW];

  reg_file8 #(.DW(DW), .NREG(NREG)) u_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (we),
    .waddr_i    (rd_idx),
    .wdata_i    (wdata),
    .rd_addr_i  (rd_idx),
    .rd_data_o  (rd_val),
    .rs_addr_i  (rs_idx),
    .rs_data_o  (rs_val),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      ready_q <= 1'b0;
      in1_q   <= '0;
      in2_q   <= '0;
      sel_q   <= '0;
      act_q   <= 1'b0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ready_q <= ready_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      sel_q   <= sel_d;
      act_q   <= act_d;
      c_q     <= c_d;
      z_q     <= z_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    sel_d   = sel_q;
    act_d   = act_q;
    c_d     = c_q;
    z_d     = z_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    we      = 1'b0;
    wdata   = bus.alu_out;

    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid && ready_q) begin
          instr_d = bus.instr;
          state_d = uses_alu(bus.instr[OPC_LSB +: 3]) ? ST_ISSUE : ST_WB;
        end
      end
      ST_ISSUE: begin
        // rs and rd are read before any writeback, so rd == rs sees the old value.
        in1_d   = instr_q[IMM_SEL_BIT] ? imm : rs_val;
        in2_d   = rd_val;
        sel_d   = opc;
        act_d   = ~act_q;
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (opc == OP_CMP) begin
          c_d = bus.alu_c;
          z_d = bus.alu_z;
        end else begin
          we = 1'b1;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_WB: begin
        if (opc == OP_LDI) begin
          we     = 1'b1;
          wdata  = imm;
          done_d = 1'b1;
        end else begin
          err_d  = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered so ready stays low through reset and rises one edge after release.
    ready_d = (state_d == ST_IDLE);
  end

  assign bus.instr_ready = ready_q;
  assign bus.alu_in1     = in1_q;
  assign bus.alu_in2     = in2_q;
  assign bus.alu_select  = sel_q;
  assign bus.alu_active  = act_q;
  assign c_flag          = c_q;
  assign z_flag          = z_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a reference model predicts each
// accepted instruction and a negedge monitor checks it when it retires.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;
  logic       c_flag, z_flag, done, err;

  alu_sequencer_if #(.DW(8)) bus ();

  alu_sequencer #(.DW(8), .NREG(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .c_flag   (c_flag),
    .z_flag   (z_flag),
    .done     (done),
    .err      (err),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: c = (in2 < in1), z = (in1 == in2).
  always_comb begin
    bus.alu_out = 8'h00;
    case (bus.alu_select)
      OP_ADD:  bus.alu_out = bus.alu_in1 + bus.alu_in2;
      OP_SUB:  bus.alu_out = bus.alu_in1 - bus.alu_in2;
      OP_AND:  bus.alu_out = bus.alu_in1 & bus.alu_in2;
      OP_OR:   bus.alu_out = bus.alu_in1 | bus.alu_in2;
      OP_XOR:  bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
      default: bus.alu_out = 8'h00;
    endcase
    bus.alu_c = (bus.alu_in2 < bus.alu_in1);
    bus.alu_z = (bus.alu_in1 == bus.alu_in2);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;   // 0 ALU op, 1 LDI, 2 illegal
    logic [2:0] rd;
    int         xfer;
    int         due;
    logic [7:0] in1, in2, val;
    logic [2:0] sel;
    logic       act, c, z;
  } sb_t;

  sb_t        sb [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         stim_to  = 1'b0;
  bit         stim_end = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs);
    return {op, 1'b0, rd, rs, 6'b0};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] rd, input logic [7:0] imm);
    return {op, 1'b1, rd, 1'b0, imm};
  endfunction

  // Holds instr_valid until accepted; leaves it high so successive calls chain.
  task automatic send(input logic [15:0] w);
    bit ok = 1'b0;
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    for (int n = 0; n < 12 && !ok; n++) begin
      @(negedge clk);
      if (bus.instr_ready) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      stim_to = 1'b1;
    end
  endtask

  initial begin : stim
    logic [2:0]  op;
    logic [15:0] w;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    rst_n           = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    send(enc_i(OP_LDI, 3'd1, 8'h05));
    send(enc_i(OP_LDI, 3'd2, 8'h0A));
    send(enc_r(OP_ADD, 3'd1, 3'd2));
    send(enc_i(OP_LDI, 3'd1, 8'h03));
    send(enc_i(OP_SUB, 3'd1, 8'h01));
    send(enc_i(OP_LDI, 3'd3, 8'h10));
    send(enc_i(OP_CMP, 3'd3, 8'h20));
    send(enc_i(OP_CMP, 3'd3, 8'h10));
    send(enc_i(OP_ILL, 3'd3, 8'h55));
    send(enc_i(OP_LDI, 3'd3, 8'h30));
    send(enc_i(OP_CMP, 3'd3, 8'h10));
    send(enc_r(OP_AND, 3'd2, 3'd1));
    send(enc_i(OP_OR,  3'd2, 8'hF0));
    send(enc_r(OP_XOR, 3'd2, 3'd2));
    send(enc_i(OP_LDI, 3'd4, 8'h81));
    send(enc_r(OP_ADD, 3'd4, 3'd4));

    for (int k = 0; k < 24; k++) begin
      op = 3'($urandom_range(0, 7));
      if (op == OP_LDI || $urandom_range(0, 1) == 1)
        w = enc_i(op, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      else
        w = enc_r(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      send(w);
    end

    bus.instr_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Abort an ADD in CAPTURE.
    send(enc_i(OP_LDI, 3'd4, 8'h07));
    send(enc_r(OP_ADD, 3'd5, 3'd4));
    bus.instr_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    send(enc_i(OP_LDI, 3'd6, 8'h33));
    send(enc_r(OP_ADD, 3'd6, 3'd6));
    bus.instr_valid = 1'b0;
    repeat (6) @(posedge clk);
    stim_end = 1'b1;
  end

  initial begin : mon
    logic [7:0] m_reg [8];
    logic       m_c, m_z, m_act;
    logic [2:0] sweep;
    int         last_xfer, last_min, rel_cnt;
    bit         have_due;
    sb_t        e;
    logic [2:0] op, rdi;
    logic [7:0] src, dst, res;

    for (int k = 0; k < 8; k++) m_reg[k] = 8'h00;
    m_c = 1'b0; m_z = 1'b0; m_act = 1'b0;
    sweep = 3'd0; last_xfer = -1; last_min = 0; rel_cnt = 0;

    forever begin
      @(negedge clk);
      have_due = (rst_n === 1'b1) && (sb.size() > 0) && (sb[0].due == cyc);
      dbg_addr = have_due ? sb[0].rd : sweep;
      #1;

      if (rst_n !== 1'b1) begin
        chk("rst_ready",  32'(bus.instr_ready), 32'd0);
        chk("rst_done",   32'(done),            32'd0);
        chk("rst_err",    32'(err),             32'd0);
        chk("rst_active", 32'(bus.alu_active),  32'd0);
        chk("rst_in1",    32'(bus.alu_in1),     32'd0);
        chk("rst_in2",    32'(bus.alu_in2),     32'd0);
        chk("rst_sel",    32'(bus.alu_select),  32'd0);
        chk("rst_flags",  32'({c_flag, z_flag}), 32'd0);
        chk("rst_reg",    32'(dbg_data),        32'd0);
        sweep = sweep + 3'd1;
        sb.delete();
        for (int k = 0; k < 8; k++) m_reg[k] = 8'h00;
        m_c = 1'b0; m_z = 1'b0; m_act = 1'b0;
        last_xfer = -1; rel_cnt = 0;
      end else begin
        if (rel_cnt == 0) chk("release_ready_low",  32'(bus.instr_ready), 32'd0);
        if (rel_cnt == 1) chk("release_ready_high", 32'(bus.instr_ready), 32'd1);
        if (rel_cnt < 2) rel_cnt++;

        if (have_due) begin
          e = sb.pop_front();
          if (e.kind == 2) begin
            chk("ill_err",  32'(err),  32'd1);
            chk("ill_done", 32'(done), 32'd0);
          end else begin
            chk("ret_done", 32'(done), 32'd1);
            chk("ret_err",  32'(err),  32'd0);
          end
          chk("ret_reg",   32'(dbg_data), 32'(e.val));
          chk("ret_flags", 32'({c_flag, z_flag}), 32'({e.c, e.z}));
          $display("txn kind=%0d rd=r%0d val=%02h c=%0b z=%0b xfer=%0d retire=%0d",
                   e.kind, e.rd, dbg_data, c_flag, z_flag, e.xfer, cyc);
        end else if (done || err) begin
          chk("spurious_done_err", 32'({done, err}), 32'd0);
        end

        if (sb.size() > 0) begin
          if (cyc < sb[0].due) chk("busy_ready", 32'(bus.instr_ready), 32'd0);
          if (sb[0].kind == 0 && sb[0].xfer + 1 == cyc) begin
            chk("issue_in1",    32'(bus.alu_in1),    32'(sb[0].in1));
            chk("issue_in2",    32'(bus.alu_in2),    32'(sb[0].in2));
            chk("issue_sel",    32'(bus.alu_select), 32'(sb[0].sel));
            chk("issue_active", 32'(bus.alu_active), 32'(sb[0].act));
          end
        end

        if (bus.instr_valid && bus.instr_ready) begin
          op  = bus.instr[15:13];
          rdi = bus.instr[11:9];
          src = bus.instr[12] ? bus.instr[7:0] : m_reg[bus.instr[8:6]];
          dst = m_reg[rdi];
          res = dst;
          case (op)
            OP_ADD: res = src + dst;
            OP_SUB: res = src - dst;
            OP_AND: res = src & dst;
            OP_OR:  res = src | dst;
            OP_XOR: res = src ^ dst;
            OP_CMP: begin m_c = (dst < src); m_z = (dst == src); end
            OP_LDI: res = bus.instr[7:0];
            default: res = dst;
          endcase
          m_reg[rdi] = res;
          e.kind = (op == OP_ILL) ? 2 : (op == OP_LDI) ? 1 : 0;
          if (e.kind == 0) m_act = ~m_act;
          e.rd   = rdi;
          e.xfer = cyc + 1;
          e.due  = cyc + 1 + ((e.kind == 0) ? 2 : 1);
          e.in1  = src;
          e.in2  = dst;
          e.sel  = op;
          e.act  = m_act;
          e.val  = res;
          e.c    = m_c;
          e.z    = m_z;
          sb.push_back(e);
          if (last_xfer >= 0) chk("spacing", 32'(e.xfer - last_xfer), 32'(last_min));
          last_xfer = e.xfer;
          last_min  = (e.kind == 0) ? 3 : 2;
        end else if (bus.instr_ready && !bus.instr_valid) begin
          last_xfer = -1;
        end
      end

      if (stim_end || cyc > 20000) begin
        chk("watchdog",     32'(cyc > 20000), 32'd0);
        chk("send_timeout", 32'(stim_to),     32'd0);
        chk("sb_drain",     32'(sb.size()),   32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
      end
    end
  end

endmodule
